regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between two writeback requesters (req0 = ALU, req1 = load/IO).
//   Arbitrates round-robin and registers the winning write for one cycle before it reaches the register file.
//   Keeps a per-register busy scoreboard so issue logic can stall on pending destination registers.
//   Sits between the execute/load units and the 8 x 19-bit register file write port (write_enable/write_reg/data_in).
// PARAMETERS
//   DATA_W    19  width of one register / write data
//   ADDR_W    3   register index width
//   NUM_REGS  8   number of registers (2**ADDR_W)
// PORTS
//   clk         in   1         single clock, all state updates on posedge
//   rst_n       in   1         reset, asynchronous assert, active-low
//   req0_valid  in   1         requester 0 has a write pending
//   req0_addr   in   ADDR_W    requester 0 destination register
//   req0_data   in   DATA_W    requester 0 write data
//   req0_ready  out  1         requester 0 write accepted this cycle
//   req1_valid  in   1         requester 1 has a write pending
//   req1_addr   in   ADDR_W    requester 1 destination register
//   req1_data   in   DATA_W    requester 1 write data
//   req1_ready  out  1         requester 1 write accepted this cycle
//   rsv_valid   in   1         issue logic reserves a destination register
//   rsv_addr    in   ADDR_W    register to reserve
//   rsv_ready   out  1         reservation accepted (target not busy)
//   rf_we       out  1         to register file write_enable
//   rf_waddr    out  ADDR_W    to register file write_reg
//   rf_wdata    out  DATA_W    to register file data_in
//   busy        out  NUM_REGS  scoreboard, bit i = register i has a reserved, unwritten result
// BEHAVIOUR
//   Reset (rst_n=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, rr_last=1 (req0 wins first tie).
//     Any in-flight write is dropped, and rf_we falls immediately with reset.
//   Handshake: valid/ready per requester; transfer when valid && ready.
//     Requester holds valid, addr, and data stable until ready.
//     readyN is combinational from the valids and rr_last. It does not depend on readyN.
//   Arbitration, every cycle:
//     - Only one valid: that requester is granted.
//     - Both valid: grant the requester != rr_last. rr_last updates to the winner on each grant.
//     - None valid: no grant, and rr_last holds.
//     At most one readyN is high per cycle.
//   Output stage: the write granted in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1 (latency 1).
//     With no grant, rf_we=0 in N+1 and rf_waddr/rf_wdata hold their last value.
//     Throughput is one write per cycle. Back-to-back grants give rf_we high on consecutive cycles.
//   Same address from both requesters in one cycle: serialized by arbitration, and the later grant's data is final.
//   Scoreboard:
//     - rsv_ready = ~busy[rsv_addr] (combinational).
//     - rsv_valid && rsv_ready sets busy[rsv_addr] at the next edge.
//     - rf_we=1 clears busy[rf_waddr] at the next edge, i.e. the edge at which the register file captures the data.
//     - Reserving a register that is being cleared this cycle is refused (busy still 1), so there is no set/clear race.
//     - A write to a non-busy register is legal: the data passes through and busy stays 0.
//   No write is ever dropped once granted. Outputs are glitch-free registered signals, except readyN and rsv_ready.
// TESTING
//   1 Reset: hold rst_n=0 with both valids high -> rf_we=0, busy=8'h00, no ready.
//     Release -> first cycle grants req0 (rr_last=1).
//   2 Single writer: req0 addr=3 data=19'h1ABCD for one cycle -> req0_ready=1 that cycle.
//     Next cycle rf_we=1, rf_waddr=3, rf_wdata=19'h1ABCD; following cycle rf_we=0.
//   3 Contention: both valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants alternate 0,1,0,1.
//     rf_we is high 4 consecutive cycles with waddr 1,2,1,2.
//   4 Scoreboard: reserve reg 5 -> busy=8'h20. Reserve reg 5 again -> rsv_ready=0.
//     req1 writes reg 5 -> busy[5] clears the edge after rf_we=1.
//     A reservation presented that same cycle is refused; retried next cycle, it is accepted.
//   5 Reset mid-operation: grant req1 addr=7, assert rst_n=0 before the next edge.
//     -> rf_we=0 immediately, no write of reg 7, busy=0.
//   6 Same-address race: both requesters valid, addr=4, data 19'h00011/19'h00022.
//     -> two rf writes in order of grant; the register holds the second granted value.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter that shares one register-file write port
//               between two writeback requesters (req0 = ALU, req1 = load/IO).
//               The winning write is registered for one cycle before it
//               drives the register file. A per-register busy scoreboard lets
//               issue logic stall on pending destination registers.
// Ports       : clk, rst_n                     clock, async active-low reset
//               req0_valid/addr/data, req0_ready  requester 0 handshake
//               req1_valid/addr/data, req1_ready  requester 1 handshake
//               rsv_valid/addr, rsv_ready      destination reservation
//               rf_we/rf_waddr/rf_wdata        register-file write port
//               busy                           scoreboard, 1 bit per register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W   = 19,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ready,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] busy
);

    // Index of the requester that won most recently (1 = req1).
    logic                rr_last_q, rr_last_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_rsv_ok;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Grants. While reset is asserted nothing can be accepted, since the
    // output stage is held clear and an accepted write would be lost.
    always_comb begin
        w_grant0 = rst_n && req0_valid && (!req1_valid || rr_last_q);
        w_grant1 = rst_n && req1_valid && (!req0_valid || !rr_last_q);
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // A register whose write is on rf_we this cycle still reads busy, so a
    // reservation against it is refused and set/clear never collide on the
    // same bit.
    assign w_rsv_ok  = ~busy_q[rsv_addr];
    assign rsv_ready = w_rsv_ok;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (rsv_valid && w_rsv_ok) begin
            w_set_mask[rsv_addr] = 1'b1;
        end
        if (rf_we_q) begin
            w_clr_mask[rf_waddr_q] = 1'b1;
        end
        // Set takes precedence: a write to a non-busy register must not
        // erase a reservation taken for a newer result in the same cycle.
        busy_d = (busy_q & ~w_clr_mask) | w_set_mask;
    end

    // Output stage next-state: address/data hold when idle, only rf_we drops.
    always_comb begin
        rr_last_d  = rr_last_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (w_grant0) begin
            rr_last_d  = 1'b0;
            rf_we_d    = 1'b1;
            rf_waddr_d = req0_addr;
            rf_wdata_d = req0_data;
        end else if (w_grant1) begin
            rr_last_d  = 1'b1;
            rf_we_d    = 1'b1;
            rf_waddr_d = req1_addr;
            rf_wdata_d = req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q  <= 1'b1;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Directed vector
//               table, hand-written reset sequences, then random traffic
//               compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 19;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    logic                clk;
    logic                rst_n;
    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_addr;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_addr;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;
    logic                rsv_valid;
    logic [ADDR_W-1:0]   rsv_addr;
    logic                rsv_ready;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [NUM_REGS-1:0] busy;

    regfile_wb_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic              rv;
        logic [ADDR_W-1:0] ra;
        logic              e_r0;
        logic              e_r1;
        logic              e_rsv;
        logic              e_we;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
        logic [7:0]        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, input logic [2:0] a0, input logic [18:0] d0,
        input logic v1, input logic [2:0] a1, input logic [18:0] d1,
        input logic rv, input logic [2:0] ra,
        input logic r0, input logic r1, input logic rs,
        input logic we, input logic [2:0] wa, input logic [18:0] wd,
        input logic [7:0] bz);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.rv = rv; v.ra = ra;
        v.e_r0 = r0; v.e_r1 = r1; v.e_rsv = rs;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_busy = bz;
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [2:0] a0, input logic [18:0] d0,
                         input logic v1, input logic [2:0] a1, input logic [18:0] d1,
                         input logic rv, input logic [2:0] ra);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rsv_valid  = rv; rsv_addr  = ra;
    endtask

    // Behavioural model state
    bit               m_last;
    bit               m_busy [NUM_REGS];
    bit               m_we;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wd;

    function automatic logic [7:0] pack_busy();
        logic [7:0] b;
        for (int k = 0; k < NUM_REGS; k++) b[k] = m_busy[k];
        return b;
    endfunction

    vec_t tbl [18];

    initial begin
        bit               p0, p1, rv;
        logic [ADDR_W-1:0] a0, a1, ra;
        logic [DATA_W-1:0] d0, d1;
        int               win;
        bit               rsv_ok;

        // Directed table; rows run from a fresh reset (last winner = req1).
        tbl[0]  = mk(1,1,19'h00101, 1,2,19'h00202, 0,0,  1,0,1, 0,0,19'h00000,   8'h00);
        tbl[1]  = mk(1,1,19'h00101, 1,2,19'h00202, 0,0,  0,1,1, 1,1,19'h00101,   8'h00);
        tbl[2]  = mk(1,1,19'h00101, 1,2,19'h00202, 0,0,  1,0,1, 1,2,19'h00202,   8'h00);
        tbl[3]  = mk(1,1,19'h00101, 1,2,19'h00202, 0,0,  0,1,1, 1,1,19'h00101,   8'h00);
        tbl[4]  = mk(0,0,19'h00000, 0,0,19'h00000, 0,0,  0,0,1, 1,2,19'h00202,   8'h00);
        tbl[5]  = mk(1,3,19'h1ABCD, 0,0,19'h00000, 0,0,  1,0,1, 0,2,19'h00202,   8'h00);
        tbl[6]  = mk(0,0,19'h00000, 0,0,19'h00000, 0,0,  0,0,1, 1,3,19'h1ABCD,   8'h00);
        tbl[7]  = mk(0,0,19'h00000, 0,0,19'h00000, 0,0,  0,0,1, 0,3,19'h1ABCD,   8'h00);
        tbl[8]  = mk(0,0,19'h00000, 0,0,19'h00000, 1,5,  0,0,1, 0,3,19'h1ABCD,   8'h00);
        tbl[9]  = mk(0,0,19'h00000, 0,0,19'h00000, 1,5,  0,0,0, 0,3,19'h1ABCD,   8'h20);
        tbl[10] = mk(0,0,19'h00000, 1,5,19'h00055, 0,5,  0,1,0, 0,3,19'h1ABCD,   8'h20);
        tbl[11] = mk(0,0,19'h00000, 0,0,19'h00000, 1,5,  0,0,0, 1,5,19'h00055,   8'h20);
        tbl[12] = mk(0,0,19'h00000, 0,0,19'h00000, 1,5,  0,0,1, 0,5,19'h00055,   8'h00);
        tbl[13] = mk(0,0,19'h00000, 0,0,19'h00000, 0,0,  0,0,1, 0,5,19'h00055,   8'h20);
        tbl[14] = mk(1,4,19'h00011, 1,4,19'h00022, 0,0,  1,0,1, 0,5,19'h00055,   8'h20);
        tbl[15] = mk(0,0,19'h00000, 1,4,19'h00022, 0,0,  0,1,1, 1,4,19'h00011,   8'h20);
        tbl[16] = mk(0,0,19'h00000, 0,0,19'h00000, 0,0,  0,0,1, 1,4,19'h00022,   8'h20);
        tbl[17] = mk(0,0,19'h00000, 0,0,19'h00000, 0,0,  0,0,1, 0,4,19'h00022,   8'h20);

        // Reset held with both requesters valid.
        rst_n = 1'b0;
        drive(1,1,19'h00101, 1,2,19'h00202, 0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rf_we",  32'(rf_we),      32'h0);
        chk("rst.busy",   32'(busy),       32'h0);
        chk("rst.ready0", 32'(req0_ready), 32'h0);
        chk("rst.ready1", 32'(req1_ready), 32'h0);
        #1 rst_n = 1'b1;
        #1;
        chk("rel.ready0", 32'(req0_ready), 32'h1);
        chk("rel.ready1", 32'(req1_ready), 32'h0);
        @(posedge clk); #1;
        drive(0,0,0, 0,0,0, 0,0);
        @(negedge clk);
        chk("rel.rf_we",    32'(rf_we),    32'h1);
        chk("rel.rf_waddr", 32'(rf_waddr), 32'h1);
        chk("rel.rf_wdata", 32'(rf_wdata), 32'h00101);
        #1 rst_n = 1'b0;
        #1;
        chk("async.rf_we", 32'(rf_we), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                  tbl[i].rv, tbl[i].ra);
            @(negedge clk);
            chk($sformatf("row%0d.ready0", i),   32'(req0_ready), 32'(tbl[i].e_r0));
            chk($sformatf("row%0d.ready1", i),   32'(req1_ready), 32'(tbl[i].e_r1));
            chk($sformatf("row%0d.rsv_ready", i), 32'(rsv_ready), 32'(tbl[i].e_rsv));
            chk($sformatf("row%0d.rf_we", i),    32'(rf_we),      32'(tbl[i].e_we));
            chk($sformatf("row%0d.rf_waddr", i), 32'(rf_waddr),   32'(tbl[i].e_wa));
            chk($sformatf("row%0d.rf_wdata", i), 32'(rf_wdata),   32'(tbl[i].e_wd));
            chk($sformatf("row%0d.busy", i),     32'(busy),       32'(tbl[i].e_busy));
            @(posedge clk); #1;
        end

        // Reset while a granted write to reg 7 is on the write port.
        drive(0,0,0, 0,0,0, 1,7);
        @(negedge clk);
        chk("mid.rsv_ready", 32'(rsv_ready), 32'h1);
        @(posedge clk); #1;
        drive(0,0,0, 1,7,19'h77777, 0,0);
        @(negedge clk);
        chk("mid.ready1", 32'(req1_ready), 32'h1);
        chk("mid.busy",   32'(busy),       32'hA0);
        @(posedge clk); #1;
        drive(0,0,0, 0,0,0, 0,0);
        chk("mid.rf_we",    32'(rf_we),    32'h1);
        chk("mid.rf_waddr", 32'(rf_waddr), 32'h7);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.rf_we",    32'(rf_we),    32'h0);
        chk("midrst.busy",     32'(busy),     32'h0);
        chk("midrst.rf_wdata", 32'(rf_wdata), 32'h0);
        @(posedge clk); #1;
        chk("midrst.rf_we2", 32'(rf_we), 32'h0);
        chk("midrst.busy2",  32'(busy),  32'h0);
        rst_n = 1'b1;

        // Random traffic against the behavioural model.
        m_last = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) m_busy[k] = 1'b0;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        p0 = 0; p1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!p0 && $urandom_range(0, 99) < 55) begin
                p0 = 1; a0 = ADDR_W'($urandom); d0 = DATA_W'($urandom);
            end
            if (!p1 && $urandom_range(0, 99) < 55) begin
                p1 = 1; a1 = ADDR_W'($urandom); d1 = DATA_W'($urandom);
            end
            rv = ($urandom_range(0, 99) < 40);
            ra = ADDR_W'($urandom);
            drive(p0, a0, d0, p1, a1, d1, rv, ra);

            if (p0 && p1) win = m_last ? 0 : 1;
            else if (p0)  win = 0;
            else if (p1)  win = 1;
            else          win = -1;
            rsv_ok = !m_busy[ra];

            @(negedge clk);
            chk("rnd.ready0",    32'(req0_ready), 32'(win == 0));
            chk("rnd.ready1",    32'(req1_ready), 32'(win == 1));
            chk("rnd.rsv_ready", 32'(rsv_ready),  32'(rsv_ok));
            chk("rnd.rf_we",     32'(rf_we),      32'(m_we));
            chk("rnd.rf_waddr",  32'(rf_waddr),   32'(m_wa));
            chk("rnd.rf_wdata",  32'(rf_wdata),   32'(m_wd));
            chk("rnd.busy",      32'(busy),       32'(pack_busy()));

            @(posedge clk);
            if (m_we) m_busy[m_wa] = 1'b0;
            if (rv && rsv_ok) m_busy[ra] = 1'b1;
            if (win == 0) begin
                m_we = 1; m_wa = a0; m_wd = d0; m_last = 1'b0; p0 = 0;
            end else if (win == 1) begin
                m_we = 1; m_wa = a1; m_wd = d1; m_last = 1'b1; p1 = 0;
            end else begin
                m_we = 0;
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
